// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings for the memory-stage data access unit: access sizes and FSM states.
package dmem_access_unit_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Size code 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_W : size;
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_ext.sv
// Load extraction: selects the addressed byte/half from the bus word and sign- or zero-extends it.
module mem_load_ext
    import dmem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_B:  result = {{24{sign & byte_v[7]}}, byte_v};
            SIZE_H:  result = {{16{sign & half_v[15]}}, half_v};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// M-stage data access unit driving a split address/data handshake bus.
// Optional macro DMEM_ALIGN_CHK_EN: trap misaligned accesses instead of forcing alignment.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memReadM,
    input  logic              memWriteM,
    input  logic [1:0]        memSizeM,
    input  logic              memSignM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] writeDataM,
    output logic [DATA_W-1:0] readDataM,
    output logic              memStallM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_data_ok,
    output logic              addrErrM,
    output logic [ADDR_W-1:0] badVAddrM
);

    state_t            state;
    state_t            state_next;
    logic              access;
    logic              misaligned;
    logic              req;
    logic              capture;
    logic [1:0]        size_n;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] rdata_q;

    assign access = memReadM | memWriteM;
    assign size_n = norm_size(memSizeM);

`ifdef DMEM_ALIGN_CHK_EN
    assign misaligned = access & (((size_n == SIZE_H) & ALUOutM[0]) |
                                  ((size_n == SIZE_W) & (ALUOutM[1:0] != 2'b00)));
    assign eff_addr   = ALUOutM;
    assign addrErrM   = misaligned & ~rst;
    assign badVAddrM  = (misaligned & ~rst) ? ALUOutM : '0;
`else
    assign misaligned = 1'b0;
    assign addrErrM   = 1'b0;
    assign badVAddrM  = '0;

    // Low address bits are silently dropped so the bus only ever sees aligned accesses.
    always_comb begin
        case (size_n)
            SIZE_H:  eff_addr = {ALUOutM[ADDR_W-1:1], 1'b0};
            SIZE_W:  eff_addr = {ALUOutM[ADDR_W-1:2], 2'b00};
            default: eff_addr = ALUOutM;
        endcase
    end
`endif

    assign lane = eff_addr[1:0];

    always_comb begin
        data_wdata = writeDataM;
        data_wstrb = 4'b1111;
        case (size_n)
            SIZE_B: begin
                data_wdata = {4{writeDataM[7:0]}};
                data_wstrb = 4'b0001 << lane;
            end
            SIZE_H: begin
                data_wdata = {2{writeDataM[15:0]}};
                data_wstrb = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!memWriteM) data_wstrb = 4'b0000;
    end

    assign data_wr   = memWriteM;
    assign data_size = memSizeM;
    assign data_addr = eff_addr;

    mem_load_ext u_load_ext (
        .rdata  (data_rdata),
        .addr   (lane),
        .size   (size_n),
        .sign   (memSignM),
        .result (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // IDLE and REQ share the request path: both complete on addr_ok, possibly with data_ok alongside.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE, S_REQ: begin
                if (access && !misaligned) begin
                    req = 1'b1;
                    if (data_addr_ok) begin
                        capture    = data_data_ok;
                        state_next = data_data_ok ? S_DONE : S_WAIT;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    capture    = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rdata_q <= '0;
        else if (capture) rdata_q <= ext_data;
    end

    assign data_req  = req & ~rst;
    assign memStallM = access & ~misaligned & (state != S_DONE) & ~rst;
    assign readDataM = (state == S_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus randomized accesses vs a byte-level model.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReadM, memWriteM, memSignM;
    logic [1:0]  memSizeM;
    logic [31:0] ALUOutM, writeDataM;
    logic [31:0] readDataM;
    logic        memStallM, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic        addrErrM;
    logic [31:0] badVAddrM;

    int total = 0;
    int bad   = 0;

    dmem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .memReadM     (memReadM),
        .memWriteM    (memWriteM),
        .memSizeM     (memSizeM),
        .memSignM     (memSignM),
        .ALUOutM      (ALUOutM),
        .writeDataM   (writeDataM),
        .readDataM    (readDataM),
        .memStallM    (memStallM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok),
        .addrErrM     (addrErrM),
        .badVAddrM    (badVAddrM)
    );

    always #5 clk = ~clk;

    // Reference load: gather the addressed bytes little-endian, then extend arithmetically.
    function automatic logic [31:0] model_load(logic [31:0] rdata, logic [31:0] addr, int nbytes, logic sgn);
        longint v = 0;
        int off = int'(addr % 4);
        for (int i = 0; i < nbytes; i++)
            v += longint'((rdata >> (8 * (off + i))) & 32'hFF) * (longint'(1) << (8 * i));
        if (sgn && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
            v -= longint'(1) << (8 * nbytes);
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        memReadM = 0; memWriteM = 0; memSizeM = 2'b10; memSignM = 0;
        ALUOutM = 0; writeDataM = 0; data_rdata = 0;
        data_addr_ok = 0; data_data_ok = 0;
    endtask

    // Runs one access as bus slave: addr_ok after a_dly cycles, data_ok d_dly cycles after that.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdv,
                             input int a_dly, input int d_dly,
                             output logic [31:0] got_read, output logic [3:0] got_strb,
                             output logic [31:0] got_wdata, output logic [31:0] got_addr,
                             output int stalls);
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata, exp_addr, exp_read, tmp;
        int nbytes, off;
        nbytes   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_addr = addr - (addr % nbytes);
        off      = int'(exp_addr % 4);
        exp_strb = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            exp_strb[i] = wr && (i >= off) && (i < off + nbytes);
            tmp = wd >> (8 * (i % nbytes));
            exp_wdata[8*i +: 8] = tmp[7:0];
        end
        exp_read = model_load(rdv, exp_addr, nbytes, sgn);
        stalls = 0; got_read = 0; got_strb = 0; got_wdata = 0; got_addr = 0;

        @(posedge clk); #1;
        memReadM = rd; memWriteM = wr; memSizeM = sz; memSignM = sgn;
        ALUOutM = addr; writeDataM = wd; data_rdata = rdv;
        for (int n = 0; n <= a_dly + d_dly; n++) begin
            data_addr_ok = (n == a_dly);
            data_data_ok = (n == a_dly + d_dly);
            #1;
            total++;
            if (memStallM !== 1'b1) begin
                bad++; $display("FAIL stall_cycle%0d: got %b want 1", n, memStallM);
            end
            if (memStallM === 1'b1) stalls++;
            total++;
            if (data_req !== (n <= a_dly)) begin
                bad++; $display("FAIL req_cycle%0d: got %b want %b", n, data_req, (n <= a_dly));
            end
            if (n <= a_dly) begin
                total++;
                if (data_addr !== exp_addr) begin
                    bad++; $display("FAIL addr_cycle%0d: got %h want %h", n, data_addr, exp_addr);
                end
            end
            if (n == 0) begin
                total++;
                if (addrErrM !== 1'b0) begin
                    bad++; $display("FAIL addr_err_aligned: got %b want 0", addrErrM);
                end
            end
            if (n == a_dly) begin
                got_strb = data_wstrb; got_wdata = data_wdata; got_addr = data_addr;
                total++;
                if (data_wstrb !== exp_strb) begin
                    bad++; $display("FAIL wstrb: got %b want %b", data_wstrb, exp_strb);
                end
                total++;
                if (data_wr !== wr || data_size !== sz) begin
                    bad++; $display("FAIL wr_size: got %b/%b want %b/%b", data_wr, data_size, wr, sz);
                end
                if (wr) begin
                    total++;
                    if (data_wdata !== exp_wdata) begin
                        bad++; $display("FAIL wdata: got %h want %h", data_wdata, exp_wdata);
                    end
                end
            end
            @(posedge clk); #1;
        end
        data_addr_ok = 0; data_data_ok = 0;
        #1;
        got_read = readDataM;
        total++;
        if (memStallM !== 1'b0) begin
            bad++; $display("FAIL done_stall: got %b want 0", memStallM);
        end
        if (rd && !wr) begin
            total++;
            if (readDataM !== exp_read) begin
                bad++; $display("FAIL load_data: got %h want %h", readDataM, exp_read);
            end
        end
        @(posedge clk); #1;
        memReadM = 0; memWriteM = 0;
        #1;
        total++;
        if (readDataM !== 32'h0 || data_req !== 1'b0) begin
            bad++; $display("FAIL after_done: read %h req %b want 0/0", readDataM, data_req);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({memStallM, data_req, addrErrM, readDataM, badVAddrM} !== 67'h0) begin
            bad++; $display("FAIL reset_outputs: stall %b req %b err %b rd %h bad %h want all 0",
                            memStallM, data_req, addrErrM, readDataM, badVAddrM);
        end
        rst = 0;
        @(posedge clk); #1;
        total++;
        if (memStallM !== 1'b0 || data_req !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: stall %b req %b want 0/0", memStallM, data_req);
        end
    endtask

    task automatic test_load_latency();
        logic [31:0] r, wdv, a; logic [3:0] s; int st;
        do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, r, s, wdv, a, st);
        total++;
        if (st != 3 || r !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lw_latency: stalls %0d data %h want 3 deadbeef", st, r);
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] r, wdv, a; logic [3:0] s; int st;
        do_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 0, 0, r, s, wdv, a, st);
        total++;
        if (r !== 32'hFFFFFF80) begin bad++; $display("FAIL lb: got %h want ffffff80", r); end
        do_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 1, 0, r, s, wdv, a, st);
        total++;
        if (r !== 32'h00000080) begin bad++; $display("FAIL lbu: got %h want 00000080", r); end
        do_access(1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h80112233, 0, 1, r, s, wdv, a, st);
        total++;
        if (r !== 32'hFFFF8011) begin bad++; $display("FAIL lh: got %h want ffff8011", r); end
    endtask

    task automatic test_store_lanes();
        logic [31:0] r, wdv, a; logic [3:0] s; int st;
        do_access(0, 1, 2'b00, 0, 32'h101, 32'h000000A5, 32'h0, 0, 1, r, s, wdv, a, st);
        total++;
        if (s !== 4'b0010 || wdv !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL sb_lanes: got %b %h want 0010 a5a5a5a5", s, wdv);
        end
        do_access(0, 1, 2'b01, 0, 32'h102, 32'h00001234, 32'h0, 0, 0, r, s, wdv, a, st);
        total++;
        if (s !== 4'b1100 || wdv !== 32'h12341234) begin
            bad++; $display("FAIL sh_lanes: got %b %h want 1100 12341234", s, wdv);
        end
    endtask

    task automatic test_addr_backpressure();
        logic [31:0] r, wdv, a; logic [3:0] s; int st;
        do_access(1, 0, 2'b10, 0, 32'h240, 32'h0, 32'hCAFEF00D, 4, 1, r, s, wdv, a, st);
        total++;
        if (st != 6) begin bad++; $display("FAIL backpressure_stalls: got %0d want 6", st); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] r, wdv, a; logic [3:0] s; int st;
        @(posedge clk); #1;
        memReadM = 1; memSizeM = 2'b10; ALUOutM = 32'h200; data_rdata = 32'h12345678;
        data_addr_ok = 1; data_data_ok = 0;
        @(posedge clk); #1;
        data_addr_ok = 0;
        #1;
        total++;
        if (data_req !== 1'b0 || memStallM !== 1'b1) begin
            bad++; $display("FAIL wait_state: req %b stall %b want 0/1", data_req, memStallM);
        end
        rst = 1; memReadM = 0;
        #1;
        total++;
        if (memStallM !== 1'b0 || data_req !== 1'b0 || readDataM !== 32'h0) begin
            bad++; $display("FAIL reset_in_wait: stall %b req %b rd %h want 0/0/0", memStallM, data_req, readDataM);
        end
        @(posedge clk); #1;
        rst = 0;
        #1;
        total++;
        if (memStallM !== 1'b0 || data_req !== 1'b0 || readDataM !== 32'h0) begin
            bad++; $display("FAIL after_reset: stall %b req %b rd %h want 0/0/0", memStallM, data_req, readDataM);
        end
        do_access(1, 0, 2'b10, 0, 32'h204, 32'h0, 32'h0BADF00D, 0, 0, r, s, wdv, a, st);
        total++;
        if (st != 1) begin bad++; $display("FAIL restart_from_idle: stalls %0d want 1", st); end
    endtask

    task automatic test_alignment();
        logic [31:0] r, wdv, a; logic [3:0] s; int st;
`ifdef DMEM_ALIGN_CHK_EN
        @(posedge clk); #1;
        memReadM = 1; memSizeM = 2'b10; ALUOutM = 32'h102;
        #1;
        total++;
        if (data_req !== 1'b0 || memStallM !== 1'b0 || addrErrM !== 1'b1 || badVAddrM !== 32'h102) begin
            bad++; $display("FAIL misaligned_lw: req %b stall %b err %b bad %h want 0/0/1/102",
                            data_req, memStallM, addrErrM, badVAddrM);
        end
        @(posedge clk); #1;
        memSizeM = 2'b01; ALUOutM = 32'h101;
        #1;
        total++;
        if (data_req !== 1'b0 || addrErrM !== 1'b1 || badVAddrM !== 32'h101) begin
            bad++; $display("FAIL misaligned_lh: req %b err %b bad %h want 0/1/101", data_req, addrErrM, badVAddrM);
        end
        @(posedge clk); #1;
        memReadM = 0;
        do_access(1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h7FFF0001, 0, 0, r, s, wdv, a, st);
        total++;
        if (r !== 32'h00007FFF) begin bad++; $display("FAIL aligned_lh: got %h want 00007fff", r); end
`else
        do_access(1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h55AA55AA, 0, 0, r, s, wdv, a, st);
        total++;
        if (a !== 32'h100 || addrErrM !== 1'b0 || badVAddrM !== 32'h0) begin
            bad++; $display("FAIL forced_align_lw: addr %h err %b bad %h want 100/0/0", a, addrErrM, badVAddrM);
        end
        do_access(0, 1, 2'b01, 0, 32'h103, 32'h0000BEEF, 32'h0, 0, 0, r, s, wdv, a, st);
        total++;
        if (a !== 32'h102 || s !== 4'b1100) begin
            bad++; $display("FAIL forced_align_sh: addr %h strb %b want 102/1100", a, s);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] r, wdv, a, addr; logic [3:0] s; int st, nb;
        logic rd, wr; logic [1:0] sz;
        for (int k = 0; k < 40; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            sz = 2'($urandom_range(0, 3));
            addr = $urandom;
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifdef DMEM_ALIGN_CHK_EN
            addr = addr - (addr % nb);
`endif
            do_access(rd, wr, sz, 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r, s, wdv, a, st);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_load_latency();
        test_load_extend();
        test_store_lanes();
        test_addr_backpressure();
        test_reset_mid_access();
        test_alignment();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
